// File: rtl/reg_sel_encoder.sv
// reg_sel_encoder: round-robin arbiter that encodes one-hot register-select requests
// into a registered register address (bit i -> address i+1) over a valid/ready handshake.
module reg_sel_encoder #(
   parameter int N_REGS = 14,
   parameter int ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [N_REGS-1:0] i_req,
   input  logic              i_out_ready,
   output logic [ADDR_W-1:0] o_reg_addr,
   output logic              o_out_valid,
   output logic [N_REGS-1:0] o_grant,
   output logic [N_REGS-1:0] o_pending
);
   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PRESENT = 1'b1;
   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_sel;
   logic [ADDR_W-1:0] r_rr_ptr;
   logic [ADDR_W-1:0] r_reg_addr;
   logic              r_out_valid;
   logic [N_REGS-1:0] r_pending;
   logic [N_REGS-1:0] r_grant;
   logic [ADDR_W-1:0] w_sel;
   logic              w_found;
   logic              w_hs;
   logic [N_REGS-1:0] w_sel_1h;
   assign w_hs     = (r_state == PRESENT) & i_out_ready;
   assign w_sel_1h = N_REGS'(1) << r_sel;
   // Lowest set bit above the pointer wins; otherwise wrap to the lowest set bit overall.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int j = N_REGS - 1; j >= 0; j--)
         if (r_pending[j]) begin
            w_sel   = ADDR_W'(j);
            w_found = 1'b1;
         end
      for (int j = N_REGS - 1; j >= 0; j--)
         if (r_pending[j] && ADDR_W'(j) > r_rr_ptr) w_sel = ADDR_W'(j);
   end
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_rr_ptr    <= ADDR_W'(N_REGS - 1);
         r_reg_addr  <= '0;
         r_out_valid <= 1'b0;
         r_pending   <= '0;
         r_grant     <= '0;
      end else begin
         r_pending <= (r_pending & ~(w_hs ? w_sel_1h : '0)) | i_req;
         r_grant   <= w_hs ? w_sel_1h : '0;
         if (r_state == IDLE && w_found) begin
            r_state     <= PRESENT;
            r_sel       <= w_sel;
            r_reg_addr  <= w_sel + ADDR_W'(1);
            r_out_valid <= 1'b1;
         end else if (w_hs) begin
            r_state     <= IDLE;
            r_rr_ptr    <= r_sel;
            r_reg_addr  <= '0;
            r_out_valid <= 1'b0;
         end
      end
   end
   assign o_reg_addr  = r_reg_addr;
   assign o_out_valid = r_out_valid;
   assign o_grant     = r_grant;
   assign o_pending   = r_pending;
endmodule

// File: tb/tb_reg_sel_encoder.sv
// tb_reg_sel_encoder: directed and random checks of reg_sel_encoder against an
// address-level behavioural model of the pending set, round-robin pointer and handshake.
module tb_reg_sel_encoder;
   localparam int N = 14;
   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic [N-1:0]  i_req = '0;
   logic          i_out_ready = 1'b0;
   logic [3:0]    o_reg_addr;
   logic          o_out_valid;
   logic [N-1:0]  o_grant;
   logic [N-1:0]  o_pending;
   int n_tests = 0;
   int n_fail = 0;
   bit [N-1:0] m_pend;
   bit [N-1:0] m_grant;
   int         m_ptr;
   bit         m_valid;
   int         m_addr;
   int         q[$];
   reg_sel_encoder dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_out_ready(i_out_ready),
      .o_reg_addr(o_reg_addr), .o_out_valid(o_out_valid), .o_grant(o_grant), .o_pending(o_pending)
   );
   always #5 i_clk = ~i_clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_pend = '0; m_grant = '0; m_ptr = N - 1; m_valid = 0; m_addr = 0;
   endtask
   // One clock edge of the reference: addresses are 1..N, pointer holds the last granted bit.
   task automatic model_edge(input bit [N-1:0] rq, input bit rdy);
      bit [N-1:0] clr;
      clr = '0;
      m_grant = '0;
      if (m_valid && rdy) begin
         clr[m_addr-1] = 1'b1;
         m_grant = clr;
         m_ptr = m_addr - 1;
         m_valid = 0;
         m_addr = 0;
      end else if (!m_valid) begin
         for (int k = 1; k <= N && !m_valid; k++)
            if (m_pend[(m_ptr + k) % N]) begin
               m_addr = (m_ptr + k) % N + 1;
               m_valid = 1;
            end
      end
      m_pend = (m_pend & ~clr) | rq;
   endtask
   task automatic check_all();
      chk("pending", 32'(o_pending), 32'(m_pend));
      chk("out_valid", 32'(o_out_valid), 32'(m_valid));
      chk("reg_addr", 32'(o_reg_addr), m_valid ? m_addr : 0);
      chk("grant", 32'(o_grant), 32'(m_grant));
   endtask
   task automatic step(input logic [N-1:0] rq, input logic rdy);
      i_req = rq;
      i_out_ready = rdy;
      if (o_out_valid && rdy) q.push_back(int'(o_reg_addr));
      @(posedge i_clk);
      model_edge(rq, rdy);
      #1;
      check_all();
   endtask
   task automatic do_reset();
      i_reset = 1'b1; i_req = '0; i_out_ready = 1'b0;
      model_reset();
      @(posedge i_clk);
      #1;
      check_all();
      i_reset = 1'b0;
   endtask
   task automatic run_xfers(input logic [N-1:0] rq, input int n);
      for (int s = 0; s < 4 * n + 8 && q.size() < n; s++) step(rq, 1'b1);
      chk("xfer_count", q.size(), n);
   endtask
   initial begin
      int ex[$];
      do_reset();
      chk("reset_addr", 32'(o_reg_addr), 0);
      step('0, 1'b0);
      step('0, 1'b1);
      // single request, address 3
      step(14'h0004, 1'b1);
      step('0, 1'b1);
      chk("single_addr", 32'(o_reg_addr), 3);
      step('0, 1'b1);
      chk("single_grant", 32'(o_grant), 32'h0004);
      step('0, 1'b1);
      chk("single_pending", 32'(o_pending), 0);
      // backpressure holds address 14
      step(14'h2000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step('0, 1'b0);
         chk("bp_hold", {o_out_valid, 4'(o_reg_addr)}, {1'b1, 4'd14});
      end
      step('0, 1'b1);
      chk("bp_grant", 32'(o_grant), 32'h2000);
      step('0, 1'b1);
      // round robin with all bits held
      do_reset();
      q.delete();
      run_xfers(14'h3FFF, 16);
      for (int i = 0; i < q.size() && i < 16; i++) chk("rr_seq", q[i], i % N + 1);
      // wrap after address 14
      do_reset();
      step(14'h2000, 1'b1);
      q.delete();
      run_xfers('0, 1);
      step('0, 1'b1);
      q.delete();
      step(14'h0003, 1'b1);
      run_xfers('0, 2);
      ex = '{1, 2};
      for (int i = 0; i < q.size() && i < 2; i++) chk("wrap_seq", q[i], ex[i]);
      // search restarts after address 5
      do_reset();
      step(14'h0010, 1'b1);
      q.delete();
      run_xfers('0, 1);
      step('0, 1'b1);
      q.delete();
      step(14'h0011, 1'b1);
      run_xfers('0, 2);
      ex = '{1, 5};
      for (int i = 0; i < q.size() && i < 2; i++) chk("prio_seq", q[i], ex[i]);
      // set wins on the handshake edge
      do_reset();
      step(14'h0004, 1'b1);
      step('0, 1'b1);
      step(14'h0004, 1'b1);
      chk("setwin_pending", 32'(o_pending), 32'h0004);
      step('0, 1'b0);
      chk("setwin_reissue", {o_out_valid, 4'(o_reg_addr)}, {1'b1, 4'd3});
      // asynchronous reset while presenting
      step(14'h0100, 1'b0);
      #3;
      i_reset = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge i_clk);
      #1;
      i_out_ready = 1'b1;
      check_all();
      i_reset = 1'b0;
      step('0, 1'b1);
      step('0, 1'b1);
      // random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) == 0) ? N'($urandom) : '0, $urandom_range(0, 2) != 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_sel_encoder.md
Name: reg_sel_encoder

Overview:
- Reverse direction of the register-address decoder: collects one-hot register-select requests from 14 producers.
- Arbitrates the requests round-robin and issues one 4-bit register address at a time over a valid/ready handshake.
- Sits between the execution units and the register-file write path; its reg_addr output drives the decoder's reg_addr input.
- Mapping is fixed: request bit i ⇔ address i+1 (1..14); address 0 = no register, never issued.

Parameters:
- N_REGS, 14, number of request lines / addressable registers; must satisfy N_REGS <= 2^ADDR_W - 1.
- ADDR_W, 4, width of the encoded register address.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REGS  request pulses/levels; bit i requests address i+1; sampled every rising edge.
- out_ready  input  1  consumer can accept reg_addr this cycle.
- reg_addr  output  ADDR_W  encoded address, registered; 0 when not valid.
- out_valid  output  1  reg_addr holds a pending request.
- grant  output  N_REGS  one-cycle one-hot pulse on the bit whose address was accepted.
- pending  output  N_REGS  current pending-request register (debug/status).

Behaviour:
- Reset (async, active-high) forces: pending=0, reg_addr=0, out_valid=0, grant=0, state=IDLE, rr_ptr=N_REGS-1. The first search therefore starts at bit 0.
- Pending capture (every edge): pending <= (pending & ~clear_mask) | req.
  - clear_mask = one-hot of the accepted bit on a handshake edge, else 0.
  - Set wins: a req on the bit being cleared in the same edge leaves it pending.
  - Repeated req on an already-pending bit is absorbed; there is no counting.
- FSM, 2 states:
  - IDLE: if pending != 0 at the edge, select the first set bit scanning rr_ptr+1, rr_ptr+2, … with wrap N_REGS-1 -> 0. Register reg_addr = sel+1 and out_valid = 1, latch sel, go to PRESENT. Otherwise stay in IDLE with out_valid = 0 and reg_addr = 0.
  - PRESENT: reg_addr and out_valid are held stable while out_ready = 0; no re-arbitration, even if a higher-priority bit arrives. On out_valid & out_ready at the edge: clear pending[sel], grant <= one-hot(sel) for exactly 1 cycle, rr_ptr <= sel, out_valid <= 0, reg_addr <= 0, go to IDLE.
- Selection uses the pending value before that edge's capture. A req arriving at edge k becomes selectable at edge k+1.
- Latency: req high at edge k -> out_valid high after edge k+1 (2 cycles), provided the FSM is IDLE and no other bits win.
- Throughput: at most 1 transfer per 2 cycles, because a mandatory IDLE cycle follows each handshake.
- grant is 0 except in the cycle immediately after a handshake edge.
- Only one grant bit is ever set. reg_addr is never 0 while out_valid = 1.
- Round-robin guarantees no starvation: with all 14 bits continuously pending, addresses are issued 1,2,…,14,1,…
- Bits of req at or above N_REGS do not exist; the arbiter index is ADDR_W bits wide, with no overflow past N_REGS-1.
- Reset mid-transfer (PRESENT, out_ready = 0): all state clears immediately. Pending requests are lost, and no grant is issued for the interrupted transfer.

Test Plan:
- Reset/idle: assert reset, req=0 -> out_valid=0, reg_addr=0, grant=0, pending=0; these stay after release.
- Single request: req=14'h0004 for 1 cycle, out_ready=1 -> reg_addr=3 with out_valid 2 cycles later; grant=14'h0004 pulse one cycle after the handshake; pending returns to 0.
- Backpressure: req=14'h2000, out_ready=0 for 10 cycles -> reg_addr=14 and out_valid held all 10 cycles. Then out_ready=1 -> grant=14'h2000 once.
- Round-robin fairness: req=14'h3FFF held, out_ready=1 -> issued sequence 1,2,…,14,1,2; one IDLE cycle between each transfer.
- Wrap and priority: after granting address 14, set req=14'h0003 -> next issued addresses are 1 then 2. After granting 5, set req=14'h0011 -> issued order is 1 then 5 (search starts at bit 5).
- Set-wins / mid-reset: re-pulse req bit 2 on its own handshake edge -> address 3 is issued again. Then assert reset while PRESENT with out_ready=0 -> outputs clear immediately and no grant is issued.
